// File: rtl/cp0_sys_ctrl.sv
// CP0 system control block: BadVAddr/Count/Compare/Status/Cause/EPC with a Count
// prescaler, per-line interrupt synchronisers and nested-exception handling.
module cp0_sys_ctrl #(
  parameter int N_HW_INT    = 6,
  parameter int TICK_DIV    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                exc_bd,
  input  logic [31:0]         exc_pc,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  input  logic [N_HW_INT-1:0] hw_int,
  output logic [31:0]         epc_out,
  output logic                exl_out,
  output logic                int_req
);

  localparam logic [3:0] PRE_MAX = 4'(TICK_DIV - 1);

  logic [31:0]         badvaddr_r;
  logic [31:0]         count_r;
  logic [31:0]         compare_r;
  logic [31:0]         epc_r;
  logic [7:0]          im_r;
  logic                exl_r;
  logic                ie_r;
  logic                bd_r;
  logic                ti_r;
  logic [5:0]          ip_hw_r;
  logic [1:0]          ip_sw_r;
  logic [4:0]          exc_code_r;
  logic [3:0]          pre_r;
  logic [N_HW_INT-1:0] sync_r [SYNC_STAGES];

  logic [5:0]  s_int_s;
  logic [7:0]  ip_s;
  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;

  assign wr_count_s   = wr_en && (addr == 8'h48);
  assign wr_compare_s = wr_en && (addr == 8'h58);
  assign wr_status_s  = wr_en && (addr == 8'h60);
  assign wr_cause_s   = wr_en && (addr == 8'h68);
  assign wr_epc_s     = wr_en && (addr == 8'h70);

  // Widen the synchronised lines to six bits; missing lines read as zero
  always_comb begin
    s_int_s = 6'd0;
    for (int i = 0; i < N_HW_INT; i++) begin
      s_int_s[i] = sync_r[SYNC_STAGES-1][i];
    end
  end

  // TI is folded into IP[15] directly so a Compare write drops int_req at once
  assign ip_s     = {ti_r | ip_hw_r[5], ip_hw_r[4:0], ip_sw_r};
  assign status_s = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
  assign cause_s  = {bd_r, ti_r, 14'd0, ip_s, 1'b0, exc_code_r, 2'b00};

  // MFC0 read mux
  always_comb begin
    case (addr)
      8'h40:   rdata = badvaddr_r;
      8'h48:   rdata = count_r;
      8'h58:   rdata = compare_r;
      8'h60:   rdata = status_s;
      8'h68:   rdata = cause_s;
      8'h70:   rdata = epc_r;
      default: rdata = 32'd0;
    endcase
  end

  // Interrupt input synchroniser chains
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Prescaled Count and sticky Compare-match flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r   <= 32'd0;
      pre_r     <= 4'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      if (wr_count_s) begin
        count_r <= wdata;
        pre_r   <= 4'd0;
      end else if (pre_r == PRE_MAX) begin
        count_r <= count_r + 32'd1;
        pre_r   <= 4'd0;
      end else begin
        pre_r   <= pre_r + 4'd1;
      end
      if (wr_compare_s) begin
        compare_r <= wdata;
        ti_r      <= 1'b0;
      end else if (count_r == compare_r) begin
        ti_r      <= 1'b1;
      end
    end
  end

  // Status, Cause, EPC and BadVAddr; exceptions outrank ERET and MTC0
  always_ff @(posedge clk) begin
    if (!rst) begin
      badvaddr_r <= 32'd0;
      epc_r      <= 32'd0;
      im_r       <= 8'd0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_hw_r    <= 6'd0;
      ip_sw_r    <= 2'd0;
      exc_code_r <= 5'd0;
    end else begin
      ip_hw_r <= s_int_s;
      if (wr_status_s) begin
        im_r <= wdata[15:8];
        ie_r <= wdata[0];
      end
      if (exc_valid) begin
        exl_r <= 1'b1;
      end else if (eret) begin
        exl_r <= 1'b0;
      end else if (wr_status_s) begin
        exl_r <= wdata[1];
      end
      if (wr_cause_s) begin
        ip_sw_r <= wdata[9:8];
      end
      if (exc_valid) begin
        exc_code_r <= exc_code;
        // A nested exception keeps the original return point
        if (!exl_r) begin
          epc_r <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          bd_r  <= exc_bd;
        end
        if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
          badvaddr_r <= exc_badvaddr;
        end
      end else if (wr_epc_s) begin
        epc_r <= wdata;
      end
    end
  end

  assign epc_out = epc_r;
  assign exl_out = exl_r;
  assign int_req = (|(ip_s & im_r)) & ie_r & ~exl_r;

endmodule

// File: tb/tb_cp0_sys_ctrl.sv
// Self-checking bench for cp0_sys_ctrl: register table, directed timer/interrupt/
// exception sequences, a one-line instance, and random traffic against a model.
module tb_cp0_sys_ctrl;

  localparam int N_HW = 6;
  localparam int TD   = 2;
  localparam int SS   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_pc = 32'd0;
  logic [31:0] exc_badvaddr = 32'd0;
  logic        eret = 1'b0;
  logic [5:0]  hw_int = 6'd0;
  logic [31:0] epc_out;
  logic        exl_out;
  logic        int_req;

  logic        wr1 = 1'b0;
  logic [7:0]  addr1 = 8'h68;
  logic [31:0] wdata1 = 32'd0;
  logic [31:0] rdata1;
  logic [0:0]  hw1 = 1'b0;
  logic [31:0] epc1;
  logic        exl1;
  logic        int1;

  cp0_sys_ctrl #(.N_HW_INT(N_HW), .TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .hw_int(hw_int),
    .epc_out(epc_out), .exl_out(exl_out), .int_req(int_req)
  );

  cp0_sys_ctrl #(.N_HW_INT(1), .TICK_DIV(TD), .SYNC_STAGES(SS)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .addr(addr1), .wdata(wdata1), .rdata(rdata1),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .hw_int(hw1),
    .epc_out(epc1), .exl_out(exl1), .int_req(int1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per rising edge
  logic [31:0] m_badv, m_count, m_cmp, m_epc;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_sw;
  logic [4:0]  m_exc;
  int          m_pre;
  logic [5:0]  m_hist[$];

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wval;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic old_exl;
    logic wcnt, wcmp, wst, wca, wepc;
    if (!rst) begin
      m_badv = 32'd0; m_count = 32'd0; m_cmp = 32'd0; m_epc = 32'd0;
      m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
      m_sw = 2'd0; m_exc = 5'd0; m_pre = 0;
      m_hist.delete();
      repeat (SS + 1) m_hist.push_back(6'd0);
    end else begin
      wcnt = wr_en && addr == 8'h48;
      wcmp = wr_en && addr == 8'h58;
      wst  = wr_en && addr == 8'h60;
      wca  = wr_en && addr == 8'h68;
      wepc = wr_en && addr == 8'h70;
      if (wcmp) m_ti = 1'b0;
      else if (m_count == m_cmp) m_ti = 1'b1;
      if (wcmp) m_cmp = wdata;
      if (wcnt) begin
        m_count = wdata;
        m_pre = 0;
      end else if (m_pre == TD - 1) begin
        m_pre = 0;
        m_count = m_count + 32'd1;
      end else begin
        m_pre++;
      end
      m_hist.push_back(hw_int);
      if (m_hist.size() > SS + 1) void'(m_hist.pop_front());
      old_exl = m_exl;
      if (wst) begin
        m_im = wdata[15:8];
        m_ie = wdata[0];
      end
      if (exc_valid) m_exl = 1'b1;
      else if (eret) m_exl = 1'b0;
      else if (wst) m_exl = wdata[1];
      if (wca) m_sw = wdata[9:8];
      if (exc_valid) begin
        m_exc = exc_code;
        if (!old_exl) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd = exc_bd;
        end
        if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
      end else if (wepc) begin
        m_epc = wdata;
      end
    end
  endtask

  function automatic logic [7:0] m_ip();
    logic [5:0] h;
    h = m_hist[$-SS];
    return {m_ti | h[5], h[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_badv;
      8'h48:   return m_count;
      8'h58:   return m_cmp;
      8'h60:   return {16'h0040, m_im, 6'd0, m_exl, m_ie};
      8'h68:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
      8'h70:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; addr = 8'd0; wdata = 32'd0; exc_valid = 1'b0; exc_code = 5'd0;
    exc_bd = 1'b0; exc_pc = 32'd0; exc_badvaddr = 32'd0; eret = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    hw_int = 6'd0;
    hw1 = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    logic [7:0] alist[6];
    bit found;
    int r;
    alist = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70};
    vt[0] = '{8'h60, 32'hFFFF_FFFF, 8'h60, 32'h0040_FF03};
    vt[1] = '{8'h60, 32'h0000_0000, 8'h60, 32'h0040_0000};
    vt[2] = '{8'h68, 32'hFFFF_FFFF, 8'h68, 32'h0000_0300};
    vt[3] = '{8'h68, 32'h0000_0000, 8'h68, 32'h0000_0000};
    vt[4] = '{8'h70, 32'h1234_5678, 8'h70, 32'h1234_5678};
    vt[5] = '{8'h40, 32'hDEAD_BEEF, 8'h40, 32'h0000_0000};
    vt[6] = '{8'h61, 32'hAAAA_AAAA, 8'h70, 32'h1234_5678};
    vt[7] = '{8'h58, 32'h0000_1000, 8'h58, 32'h0000_1000};
    vt[8] = '{8'h60, 32'h0000_0402, 8'h60, 32'h0040_0402};

    // Reset state
    do_reset();
    rd("rst_status", 8'h60, 32'h0040_0000);
    rd("rst_cause", 8'h68, 32'h0000_0000);
    chk("rst_int_req", int_req, 32'd0);
    chk("rst_exl", exl_out, 32'd0);
    chk("rst_epc", epc_out, 32'd0);

    // Register write masks
    wr(8'h58, 32'hFFFF_0000);
    for (int i = 0; i < 9; i++) begin
      wr(vt[i].waddr, vt[i].wval);
      rd($sformatf("tbl%0d", i), vt[i].raddr, vt[i].exp);
    end

    // Prescaled count and compare timer
    do_reset();
    wr(8'h60, 32'h0000_8001);
    wr(8'h58, 32'd12);
    wr(8'h48, 32'd5);
    rd("t2_load", 8'h48, 32'd5);
    repeat (10) tick();
    rd("t2_count10", 8'h48, 32'd10);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      addr = 8'h48;
      #1;
      if (rdata == 32'd12) found = 1'b1;
      else tick();
    end
    chk("t2_reach12", found, 32'd1);
    addr = 8'h68; #1;
    chk("t2_ti_before", rdata[30], 32'd0);
    tick();
    addr = 8'h68; #1;
    chk("t2_ti_set", rdata[30], 32'd1);
    chk("t2_int_set", int_req, 32'd1);
    wr(8'h58, 32'd12);
    addr = 8'h68; #1;
    chk("t2_ti_clear", rdata[30], 32'd0);
    chk("t2_int_clear", int_req, 32'd0);
    rd("t2_count13", 8'h48, 32'd13);

    // Interrupt latency and exception masking
    do_reset();
    wr(8'h60, 32'h0000_0401);
    hw_int = 6'b000001;
    tick(); chk("t3_lat1", int_req, 32'd0);
    tick(); chk("t3_lat2", int_req, 32'd0);
    tick(); chk("t3_lat3", int_req, 32'd1);
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h200; exc_bd = 1'b0;
    tick(); idle();
    chk("t3_exl", exl_out, 32'd1);
    chk("t3_int_masked", int_req, 32'd0);
    chk("t3_epc", epc_out, 32'h200);
    eret = 1'b1;
    tick(); idle();
    chk("t3_eret_exl", exl_out, 32'd0);
    chk("t3_int_again", int_req, 32'd1);
    hw_int = 6'd0;

    // Address errors in a delay slot, then a nested exception
    exc_valid = 1'b1; exc_code = 5'd4; exc_bd = 1'b1;
    exc_pc = 32'hBFC0_0104; exc_badvaddr = 32'h3;
    tick(); idle();
    chk("t4_epc", epc_out, 32'hBFC0_0100);
    rd("t4_badv", 8'h40, 32'h3);
    addr = 8'h68; #1;
    chk("t4_cause", rdata & 32'h8000_007C, 32'h8000_0010);
    exc_valid = 1'b1; exc_code = 5'd5; exc_bd = 1'b0;
    exc_pc = 32'h100; exc_badvaddr = 32'h7;
    tick(); idle();
    chk("t4_nested_epc", epc_out, 32'hBFC0_0100);
    rd("t4_ades_badv", 8'h40, 32'h7);
    addr = 8'h68; #1;
    chk("t4_nested_cause", rdata & 32'h8000_007C, 32'h8000_0014);

    // Same-cycle priority cases
    eret = 1'b1; tick(); idle();
    chk("t5_eret", exl_out, 32'd0);
    exc_valid = 1'b1; eret = 1'b1; exc_pc = 32'h300;
    tick(); idle();
    chk("t5_exc_eret_exl", exl_out, 32'd1);
    chk("t5_exc_eret_epc", epc_out, 32'h300);
    eret = 1'b1; tick(); idle();
    exc_valid = 1'b1; exc_pc = 32'h400; wr_en = 1'b1; addr = 8'h70; wdata = 32'h1234;
    tick(); idle();
    chk("t5_exc_vs_mtc0", epc_out, 32'h400);

    // Single interrupt line instance
    do_reset();
    wr1 = 1'b1; addr1 = 8'h58; wdata1 = 32'hFFFF_0000; tick();
    addr1 = 8'h68; wdata1 = 32'h0000_0300; tick();
    wr1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      hw1 = 1'($urandom);
      tick();
      chk("t6_upper_ip", {27'd0, rdata1[15:11]}, 32'd0);
      chk("t6_sw_ip", {30'd0, rdata1[9:8]}, 32'd3);
    end
    hw1 = 1'b1;
    repeat (4) tick();
    chk("t6_ip10", rdata1[10], 32'd1);

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      exc_valid = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 3);
      exc_code = (r == 0) ? 5'd4 : (r == 1) ? 5'd5 : 5'($urandom);
      exc_bd = 1'($urandom);
      exc_pc = $urandom;
      exc_badvaddr = $urandom;
      wr_en = !exc_valid && ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 6);
      addr = (r == 6) ? 8'($urandom) : alist[r];
      if (addr == 8'h48) wdata = m_cmp - 32'($urandom_range(0, 4));
      else if (addr == 8'h58) wdata = m_count + 32'($urandom_range(0, 4));
      else wdata = $urandom;
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      hw1 = 1'($urandom);
      #1;
      chk("rnd_rdata", rdata, m_read(addr));
      chk("rnd_int_req", int_req, m_int());
      chk("rnd_epc", epc_out, m_epc);
      chk("rnd_exl", exl_out, m_exl);
      chk("rnd_n1_ip", {27'd0, rdata1[14:11], rdata1[15] ^ rdata1[30]}, 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic m_int();
    return (|(m_ip() & m_im)) & m_ie & ~m_exl;
  endfunction

endmodule
